// File: rtl/score_lives_keeper_if.sv
// Bundles the game-event inputs and the digit/status outputs of score_lives_keeper.
// The master drives the button and hit/miss events; the slave (the keeper) drives the digits.
interface score_lives_keeper_if;
  logic       start;
  logic       hit;
  logic       miss;
  logic [3:0] score_ones;
  logic [3:0] score_tens;
  logic [3:0] lives;
  logic [3:0] hi_ones;
  logic [3:0] hi_tens;
  logic [1:0] game_state;
  logic       game_over;

  modport master (
    output start, hit, miss,
    input  score_ones, score_tens, lives, hi_ones, hi_tens, game_state, game_over
  );

  modport slave (
    input  start, hit, miss,
    output score_ones, score_tens, lives, hi_ones, hi_tens, game_state, game_over
  );
endinterface

// File: rtl/score_lives_keeper.sv
// Score, lives and high-score bookkeeping with the IDLE/PLAY/OVER game FSM.
// All outputs come straight from flops so they can feed the seven-segment scan directly.
//
// state | meaning
// IDLE  | after reset, waiting for the first start press
// PLAY  | game running, hit/miss events update score and lives
// OVER  | lives exhausted, score/lives frozen, high score updated on entry
module score_lives_keeper #(
  parameter int unsigned INIT_LIVES = 3,
  parameter int unsigned MAX_LIVES  = 9
) (
  input  logic                  ClkPort,
  input  logic                  Reset,
  score_lives_keeper_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [3:0] INIT_L = 4'(INIT_LIVES);
  localparam logic [3:0] MAX_L  = 4'(MAX_LIVES);

  state_t     state_q, state_n;
  logic [3:0] score_ones_q, score_ones_n;
  logic [3:0] score_tens_q, score_tens_n;
  logic [3:0] lives_q, lives_n;
  logic [3:0] hi_ones_q, hi_ones_n;
  logic [3:0] hi_tens_q, hi_tens_n;
  logic       game_over_q;
  logic       bonus;
  logic [4:0] lives_sum;

  logic s1, s2, s3;
  logic start_edge;

  // Two-flop synchronizer plus history flop so a held button yields one edge.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.start;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_edge = s2 & ~s3;

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      score_ones_q <= 4'd0;
      score_tens_q <= 4'd0;
      lives_q      <= INIT_L;
      hi_ones_q    <= 4'd0;
      hi_tens_q    <= 4'd0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      score_ones_q <= score_ones_n;
      score_tens_q <= score_tens_n;
      lives_q      <= lives_n;
      hi_ones_q    <= hi_ones_n;
      hi_tens_q    <= hi_tens_n;
      game_over_q  <= (state_n == OVER);
    end
  end

  always_comb begin
    state_n      = state_q;
    score_ones_n = score_ones_q;
    score_tens_n = score_tens_q;
    lives_n      = lives_q;
    hi_ones_n    = hi_ones_q;
    hi_tens_n    = hi_tens_q;
    bonus        = 1'b0;
    lives_sum    = {1'b0, lives_q};

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_n      = PLAY;
          score_ones_n = 4'd0;
          score_tens_n = 4'd0;
          lives_n      = INIT_L;
        end
      end

      PLAY: begin
        if (bus.hit && !(score_ones_q == 4'd9 && score_tens_q == 4'd9)) begin
          if (score_ones_q == 4'd9) begin
            score_ones_n = 4'd0;
            score_tens_n = score_tens_q + 4'd1;
            bonus        = 1'b1;
          end else begin
            score_ones_n = score_ones_q + 4'd1;
          end
        end

        // Bonus and miss are netted first, then clamped, so a same-cycle pair never moves lives.
        lives_sum = {1'b0, lives_q} + {4'd0, bonus} - {4'd0, bus.miss};
        if (lives_sum > {1'b0, MAX_L}) begin
          lives_n = MAX_L;
        end else begin
          lives_n = lives_sum[3:0];
        end

        if (bus.miss && lives_sum == 5'd0) begin
          state_n = OVER;
          // Packed BCD digits order the same way as the binary value, so one compare suffices.
          if ({score_tens_n, score_ones_n} > {hi_tens_q, hi_ones_q}) begin
            hi_tens_n = score_tens_n;
            hi_ones_n = score_ones_n;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.score_ones = score_ones_q;
  assign bus.score_tens = score_tens_q;
  assign bus.lives      = lives_q;
  assign bus.hi_ones    = hi_ones_q;
  assign bus.hi_tens    = hi_tens_q;
  assign bus.game_state = state_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_score_lives_keeper.sv
// Self-checking bench for score_lives_keeper: fixed vector table, directed corner
// sequences and randomized events, all compared against an integer game model.
module tb_score_lives_keeper;

  localparam int INIT_LIVES = 3;
  localparam int MAX_LIVES  = 9;

  logic ClkPort;
  logic Reset;
  logic st_lvl;

  score_lives_keeper_if bus ();

  score_lives_keeper #(
    .INIT_LIVES (INIT_LIVES),
    .MAX_LIVES  (MAX_LIVES)
  ) dut (
    .ClkPort (ClkPort),
    .Reset   (Reset),
    .bus     (bus)
  );

  initial begin
    ClkPort = 1'b0;
    forever #5 ClkPort = ~ClkPort;
  end

  int checks = 0;
  int errors = 0;

  // Game model: states 0 idle, 1 play, 2 over; score as a plain integer 0..99.
  int m_state, m_score, m_lives, m_hi;
  bit hist [3];   // start samples from one, two and three edges ago

  task automatic model_reset();
    m_state = 0;
    m_score = 0;
    m_lives = INIT_LIVES;
    m_hi    = 0;
    for (int i = 0; i < 3; i++) hist[i] = 1'b0;
  endtask

  task automatic model_edge(input bit st, input bit h, input bit m);
    bit pressed;
    int bonus;
    pressed = hist[1] && !hist[2];
    if (m_state == 0 || m_state == 2) begin
      if (pressed) begin
        m_state = 1;
        m_score = 0;
        m_lives = INIT_LIVES;
      end
    end else begin
      bonus = 0;
      if (h && m_score < 99) begin
        if (m_score % 10 == 9) bonus = 1;
        m_score = m_score + 1;
      end
      m_lives = m_lives + bonus - (m ? 1 : 0);
      if (m_lives > MAX_LIVES) m_lives = MAX_LIVES;
      if (m_lives == 0) begin
        m_state = 2;
        if (m_score > m_hi) m_hi = m_score;
      end
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = st;
  endtask

  task automatic check_model(input string tag);
    checks++;
    if (int'(bus.score_ones) != m_score % 10 || int'(bus.score_tens) != m_score / 10 ||
        int'(bus.lives) != m_lives || int'(bus.hi_ones) != m_hi % 10 ||
        int'(bus.hi_tens) != m_hi / 10 || int'(bus.game_state) != m_state ||
        bus.game_over != (m_state == 2)) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d sc=%0d%0d lv=%0d hi=%0d%0d go=%0b want st=%0d sc=%0d lv=%0d hi=%0d",
               tag, $time, bus.game_state, bus.score_tens, bus.score_ones, bus.lives,
               bus.hi_tens, bus.hi_ones, bus.game_over, m_state, m_score, m_lives, m_hi);
    end
  endtask

  task automatic expect_vals(input string tag, input int st, input int sc, input int lv, input int hi);
    checks++;
    if (int'(bus.score_ones) != sc % 10 || int'(bus.score_tens) != sc / 10 ||
        int'(bus.lives) != lv || int'(bus.hi_ones) != hi % 10 ||
        int'(bus.hi_tens) != hi / 10 || int'(bus.game_state) != st ||
        bus.game_over != (st == 2)) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d sc=%0d%0d lv=%0d hi=%0d%0d go=%0b want st=%0d sc=%0d lv=%0d hi=%0d",
               tag, $time, bus.game_state, bus.score_tens, bus.score_ones, bus.lives,
               bus.hi_tens, bus.hi_ones, bus.game_over, st, sc, lv, hi);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit st, input bit h, input bit m);
    bus.start = st;
    bus.hit   = h;
    bus.miss  = m;
    @(posedge ClkPort);
    model_edge(st, h, m);
    @(negedge ClkPort);
    check_model("cycle");
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic misses(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic press_start();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Asserts Reset between clock edges and checks the outputs clear before any edge.
  task automatic do_reset();
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    st_lvl    = 1'b0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    expect_vals("async_reset", 0, 0, INIT_LIVES, 0);
    @(negedge ClkPort);
    Reset = 1'b0;
  endtask

  typedef struct {
    bit st;
    bit h;
    bit m;
    int e_state;
    int e_score;
    int e_lives;
    int e_hi;
  } vec_t;

  vec_t tbl [16];

  initial begin
    // Start held five cycles, then a short game ending at score 07.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 0, 3, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 0, 0, 3, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1, 0, 3, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1, 0, 3, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1, 0, 3, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1, 1, 3, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1, 2, 3, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 3, 3, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1, 3, 2, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1, 4, 1, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1, 5, 1, 0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1, 6, 1, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 7, 1, 0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 2, 7, 0, 7};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2, 7, 0, 7};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 2, 7, 0, 7};

    Reset     = 1'b1;
    bus.start = 1'b0;
    bus.hit   = 1'b0;
    bus.miss  = 1'b0;
    st_lvl    = 1'b0;
    model_reset();
    repeat (3) @(negedge ClkPort);
    Reset = 1'b0;
    expect_vals("reset_state", 0, 0, INIT_LIVES, 0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].st, tbl[i].h, tbl[i].m);
      expect_vals($sformatf("table[%0d]", i), tbl[i].e_state, tbl[i].e_score,
                  tbl[i].e_lives, tbl[i].e_hi);
    end

    // Tens carry gives a bonus life; 99 saturates with no bonus.
    press_start();
    expect_vals("restart_keeps_hi", 1, 0, 3, 7);
    hits(10);
    expect_vals("carry_bonus", 1, 10, 4, 7);
    hits(89);
    expect_vals("reach_99", 1, 99, 9, 7);
    hits(1);
    expect_vals("sat_99", 1, 99, 9, 7);

    do_reset();

    // Same-cycle hit and miss with a carry keeps the last life.
    press_start();
    hits(9);
    misses(2);
    expect_vals("score9_life1", 1, 9, 1, 0);
    step(1'b0, 1'b1, 1'b1);
    expect_vals("hit_miss_bonus", 1, 10, 1, 0);
    misses(1);
    expect_vals("over_at_10", 2, 10, 0, 10);

    do_reset();

    // Same-cycle hit and miss without carry ends the game, counting the hit.
    press_start();
    hits(5);
    misses(2);
    step(1'b0, 1'b1, 1'b1);
    expect_vals("hit_miss_over", 2, 6, 0, 6);
    step(1'b0, 1'b1, 1'b1);
    expect_vals("over_frozen", 2, 6, 0, 6);

    // A lower later score leaves the high score alone.
    press_start();
    hits(12);
    misses(4);
    expect_vals("hi_12", 2, 12, 0, 12);
    press_start();
    expect_vals("restart_hi_12", 1, 0, 3, 12);
    hits(4);
    misses(3);
    expect_vals("lower_score_hi_kept", 2, 4, 0, 12);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 15) == 0) st_lvl = ~st_lvl;
        step(st_lvl, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
